// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the FSM state encoding, the reverse double-dabble correction
// constants and the minimum-width helper used by the elaboration check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A post-shift digit at or above this value came from a decimal
    // weight of 10 and must be pulled back down by 3 (16 -> 10 scaling).
    localparam logic [3:0] BCD_CORR_THRESH = 4'h8;
    localparam logic [3:0] BCD_CORR_VAL    = 4'h3;

    // Smallest binary width able to hold every value of a `digits`-digit
    // BCD number: ceil(log2(10^digits)).
    function automatic int bin_w_min(input int digits);
        longint unsigned pow10;
        int              w;
        pow10 = 64'd1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        w = 0;
        for (int b = 0; b < 63; b++) begin
            if ((64'd1 << b) < pow10) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_bin_dsub.sv
// One digit slice of the reverse double-dabble shifter.
// Shifts the digit right by one (taking the bit from the digit above),
// hands its LSB to the digit below, and applies the -3 correction when
// the shifted digit is 8 or more. Purely combinational.
module bcd_seg_dsub
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       shift_in_i,
    output logic [3:0] digit_o,
    output logic       shift_out_o
);

    logic [3:0] shifted;

    // Shift then correct; the subtraction cannot underflow because it only
    // fires for shifted >= 8.
    always_comb begin
        shifted     = {shift_in_i, digit_i[3:1]};
        shift_out_o = digit_i[0];
        if (shifted >= BCD_CORR_THRESH) begin
            digit_o = shifted - BCD_CORR_VAL;
        end else begin
            digit_o = shifted;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble).
// start/done handshake: start is sampled only while idle; a conversion
// then runs BIN_W shift cycles (busy high) and finishes with a one-cycle
// done pulse on which bin_out/err are already valid. Requests arriving
// while busy or during done are dropped, never queued.
// Optional feature: define BCD2BIN_DIGIT_CHECK_EN to reject inputs that
// contain a digit above 9 (err=1, bin_out=0, immediate done).
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output state_e                state_dbg
);

    localparam int              CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    if (DIGITS < 1 || DIGITS > 8 || BIN_W < bin_w_min(DIGITS)) begin : g_width_chk
        $error("bcd_to_bin: DIGITS must be 1..8 and 2**BIN_W >= 10**DIGITS");
    end

    state_e                state_q, state_d;
    logic [4*DIGITS-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0]      bin_sr_q, bin_sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIN_W-1:0]      bin_out_q, bin_out_d;
    logic                  err_q, err_d;

    logic [4*DIGITS-1:0]   bcd_shift;
    logic [DIGITS:0]       carry;
    logic                  bad_digit;
    logic                  last_shift;

    // Digit chain: carry[d+1] enters digit d, carry[0] leaves into bin_sr.
    assign carry[DIGITS] = 1'b0;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_seg_dsub u_dsub (
            .digit_i     (bcd_sr_q[4*d +: 4]),
            .shift_in_i  (carry[d+1]),
            .digit_o     (bcd_shift[4*d +: 4]),
            .shift_out_o (carry[d])
        );
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    // Flag any incoming digit outside 0..9.
    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    assign last_shift = (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a rejected input skips the shift phase entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = bad_digit ? DONE : SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy      = (state_q == SHIFT);
        done      = (state_q == DONE);
        bin_out   = bin_out_q;
        state_dbg = state_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err       = err_q;
`else
        err       = 1'b0;
`endif
    end

    // Datapath next values: load on accept, shift/correct while busy, and
    // publish the result on the last shift so it is valid during done.
    always_comb begin
        bcd_sr_d  = bcd_sr_q;
        bin_sr_d  = bin_sr_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_sr_d = bcd_in;
                    bin_sr_d = '0;
                    cnt_d    = '0;
                    if (bad_digit) begin
                        bin_out_d = '0;
                        err_d     = 1'b1;
                    end
                end
            end
            SHIFT: begin
                bcd_sr_d = bcd_shift;
                bin_sr_d = {carry[0], bin_sr_q[BIN_W-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    bin_out_d = {carry[0], bin_sr_q[BIN_W-1:1]};
                    err_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_sr_q  <= '0;
            bin_sr_q  <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            bcd_sr_q  <= bcd_sr_d;
            bin_sr_q  <= bin_sr_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed vectors plus a decimal-model sweep on a
// 4-digit/14-bit instance and a full sweep on a 2-digit/7-bit instance.
module tb_bcd_to_bin;
    import bcd_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy, done, err;
    logic [13:0] bin_out;
    state_e      state_dbg;

    logic        start2;
    logic [7:0]  bcd_in2;
    logic        busy2, done2, err2;
    logic [6:0]  bin_out2;
    state_e      state_dbg2;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err),
        .state_dbg(state_dbg)
    );

    bcd_to_bin #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd_in2),
        .busy(busy2), .done(done2), .bin_out(bin_out2), .err(err2),
        .state_dbg(state_dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drive a one-cycle start and wait for done on the 4-digit instance.
    task automatic convert(input logic [15:0] bcd, output logic [13:0] res,
                           output logic e, output int lat, output int bcnt);
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        bcnt = 0;
        res  = '0;
        e    = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) begin
                res = bin_out;
                e   = err;
                break;
            end
        end
        if (lat >= 100) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert2(input logic [7:0] bcd, output logic [6:0] res, output int lat);
        @(negedge clk);
        bcd_in2 = bcd;
        start2  = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        lat = 0;
        res = '0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done2) begin
                res = bin_out2;
                break;
            end
        end
        if (lat >= 100) check("done2_timeout", 32'd0, 32'd1);
    endtask

    // Hand-computed directed vectors.
    logic [15:0] vec_bcd [10] = '{16'h1234, 16'h9999, 16'h0000, 16'h0042, 16'h0001,
                                  16'h0100, 16'h0509, 16'h8000, 16'h0010, 16'h4096};
    logic [13:0] vec_bin [10] = '{14'h04D2, 14'h270F, 14'h0000, 14'h002A, 14'h0001,
                                  14'h0064, 14'h01FD, 14'h1F40, 14'h000A, 14'h1000};

    initial begin
        logic [13:0] res;
        logic [6:0]  res2;
        logic        e;
        int          lat, bcnt, ndone;
        int          dcyc [3];

        rst = 1'b1; start = 1'b0; bcd_in = '0; start2 = 1'b0; bcd_in2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // First conversion: latency and busy length.
        convert(16'h1234, res, e, lat, bcnt);
        check("lat_1234", 32'(lat), 32'd15);
        check("busy_1234", 32'(bcnt), 32'd14);
        check("bin_1234", 32'(res), 32'h04D2);
        check("err_1234", 32'(e), 32'd0);
        @(negedge clk);
        check("done_pulse_1cyc", 32'(done), 32'd0);
        check("bin_hold", 32'(bin_out), 32'h04D2);

        for (int i = 0; i < 10; i++) begin
            convert(vec_bcd[i], res, e, lat, bcnt);
            check($sformatf("vec_%04h", vec_bcd[i]), 32'(res), 32'(vec_bin[i]));
            check($sformatf("vec_err_%04h", vec_bcd[i]), 32'(e), 32'd0);
        end

        // start held high: one conversion every 16 cycles, nothing queued.
        @(negedge clk);
        bcd_in = 16'h0042;
        start  = 1'b1;
        ndone  = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) dcyc[ndone] = c;
                ndone++;
                check("cont_bin", 32'(bin_out), 32'h002A);
            end
        end
        start = 1'b0;
        check("cont_count", 32'(ndone), 32'd3);
        check("cont_period_a", 32'(dcyc[1] - dcyc[0]), 32'd16);
        check("cont_period_b", 32'(dcyc[2] - dcyc[1]), 32'd16);
        repeat (20) @(negedge clk);
        check("cont_drain_busy", 32'(busy), 32'd0);
        check("cont_drain_state", 32'(state_dbg), 32'(IDLE));

        // Reset in the middle of a conversion.
        @(negedge clk);
        bcd_in = 16'h5000;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bcnt = 0;
        while (bcnt < 7) begin
            @(negedge clk);
            if (busy) bcnt++;
            else begin
                check("mid_rst_busy_seen", 32'(busy), 32'd1);
                bcnt = 7;
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_bin_out", 32'(bin_out), 32'd0);
        convert(16'h0007, res, e, lat, bcnt);
        check("after_rst_bin", 32'(res), 32'h0007);
        check("after_rst_lat", 32'(lat), 32'd15);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        convert(16'h12A4, res, e, lat, bcnt);
        check("bad_lat", 32'(lat), 32'd1);
        check("bad_busy", 32'(bcnt), 32'd0);
        check("bad_err", 32'(e), 32'd1);
        check("bad_bin", 32'(res), 32'd0);
        convert(16'h0001, res, e, lat, bcnt);
        check("good_err", 32'(e), 32'd0);
        check("good_bin", 32'(res), 32'd1);
`endif

        // Sparse sweep of the 4-digit range against decimal arithmetic.
        for (int v = 0; v < 10000; v += 97) begin
            convert(to_bcd4(v), res, e, lat, bcnt);
            check($sformatf("sweep4_%0d", v), 32'(res), 32'(v));
        end
        convert(to_bcd4(9998), res, e, lat, bcnt);
        check("sweep4_9998", 32'(res), 32'd9998);

        // Full sweep of the 2-digit instance.
        for (int v = 0; v < 100; v++) begin
            convert2({4'(v / 10), 4'(v % 10)}, res2, lat);
            check($sformatf("sweep2_%0d", v), 32'(res2), 32'(v));
            if (v == 0) check("lat2", 32'(lat), 32'd8);
        end
        check("err2_valid", 32'(err2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
